// File: rtl/muldiv_core.sv
// MIPS-style multiply/divide unit holding the architectural HI/LO pair.
// Multiply uses a registered operand pair and a fixed wait; divide is radix-2 restoring.
module muldiv_core #(
  parameter int unsigned MUL_LATENCY = 5,
  parameter int unsigned DIV_LATENCY = 32
) (
  input  logic        Clk,
  input  logic        Clr_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  input  logic        op,
  input  logic        sign,
  input  logic [1:0]  WriteEnable,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] a_q, b_q, quo_q, rem_q, dvs_q;
  logic        sign_q, negq_q, negr_q, dvz_q;
  logic [31:0] hi_q, lo_q;
  logic        busy_q;

  logic [63:0] prod_d;
  logic [32:0] rem_sh, diff;
  logic        ge;
  logic [31:0] rem_d, quo_d, q_fin, r_fin;

  // Sign-extending to 64 bits makes the low 64 product bits correct for both modes.
  assign prod_d = {{32{sign_q & a_q[31]}}, a_q} * {{32{sign_q & b_q[31]}}, b_q};

  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvs_q};
    ge     = ~diff[32];
    rem_d  = ge ? diff[31:0] : rem_sh[31:0];
    quo_d  = {quo_q[30:0], ge};
    q_fin  = negq_q ? (32'd0 - quo_d) : quo_d;
    r_fin  = negr_q ? (32'd0 - rem_d) : rem_d;
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      sign_q  <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dvz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            sign_q  <= sign;
            quo_q   <= (sign && A[31]) ? (32'd0 - A) : A;
            dvs_q   <= (sign && B[31]) ? (32'd0 - B) : B;
            rem_q   <= '0;
            negq_q  <= sign & (A[31] ^ B[31]);
            negr_q  <= sign & A[31];
            dvz_q   <= (B == 32'd0);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= op ? DIV : MUL;
          end else begin
            if (WriteEnable[1]) hi_q <= A;
            if (WriteEnable[0]) lo_q <= A;
          end
        end
        MUL: begin
          if (cnt_q == 8'(MUL_LATENCY - 1)) begin
            {hi_q, lo_q} <= prod_d;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          // The last iteration's result is written straight into HI/LO on the completing edge.
          if (cnt_q == 8'(DIV_LATENCY - 1)) begin
            if (dvz_q) begin
              hi_q <= a_q;
              lo_q <= '1;
            end else begin
              hi_q <= r_fin;
              lo_q <= q_fin;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign Busy = busy_q;

endmodule

// File: tb/tb_muldiv_core.sv
// Directed self-checking bench for muldiv_core: latency, results, MT writes, ignores and abort.
module tb_muldiv_core;

  logic        Clk = 1'b0;
  logic        Clr_n = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        sign = 1'b0;
  logic [1:0]  WriteEnable = '0;
  logic [31:0] HI, LO;
  logic        Busy;

  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  muldiv_core #(.MUL_LATENCY(5), .DIV_LATENCY(32)) dut (
    .Clk(Clk), .Clr_n(Clr_n), .A(A), .B(B), .start(start), .op(op), .sign(sign),
    .WriteEnable(WriteEnable), .HI(HI), .LO(LO), .Busy(Busy)
  );

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic o, input logic s,
                        input int lat, input logic [31:0] ehi, input logic [31:0] elo,
                        input string nm);
    int n;
    logic [31:0] hi0, lo0;
    logic held;
    @(negedge Clk);
    A = a; B = b; op = o; sign = s; start = 1'b1;
    hi0 = HI; lo0 = LO;
    @(negedge Clk);
    start = 1'b0; A = 32'h5A5A5A5A; B = 32'hA5A5A5A5;
    n = 0; held = 1'b1;
    while (Busy && n < 200) begin
      n++;
      if (HI !== hi0 || LO !== lo0) held = 1'b0;
      @(negedge Clk);
    end
    total++;
    if (n !== lat) $display("FAIL %s_latency got %0d exp %0d", nm, n, lat); else passed++;
    total++;
    if (held !== 1'b1) $display("FAIL %s_hold HI/LO changed while busy got %0b exp 1", nm, held); else passed++;
    total++;
    if (HI !== ehi) $display("FAIL %s_HI got %h exp %h", nm, HI, ehi); else passed++;
    total++;
    if (LO !== elo) $display("FAIL %s_LO got %h exp %h", nm, LO, elo); else passed++;
  endtask

  task automatic test_reset();
    #3 Clr_n = 1'b0;
    #4;
    total++; if (HI !== 32'h0) $display("FAIL reset_HI got %h exp %h", HI, 32'h0); else passed++;
    total++; if (LO !== 32'h0) $display("FAIL reset_LO got %h exp %h", LO, 32'h0); else passed++;
    total++; if (Busy !== 1'b0) $display("FAIL reset_Busy got %b exp 0", Busy); else passed++;
    repeat (2) @(negedge Clk);
    Clr_n = 1'b1;
  endtask

  task automatic test_mul();
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 5, 32'hFFFFFFFE, 32'h00000001, "mulu_max");
    run_op(32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b1, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult_m1x2");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 5, 32'h00000000, 32'h00000001, "mult_m1xm1");
    run_op(32'h00012345, 32'h00010000, 1'b0, 1'b0, 5, 32'h00000001, 32'h23450000, "mulu_small");
    run_op(32'h80000000, 32'h80000000, 1'b0, 1'b1, 5, 32'h40000000, 32'h00000000, "mult_minsq");
  endtask

  task automatic test_div();
    run_op(32'hFFFFFFF9, 32'h00000002, 1'b1, 1'b1, 32, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7by2");
    run_op(32'hFFFFFFF9, 32'h00000002, 1'b1, 1'b0, 32, 32'h00000001, 32'h7FFFFFFC, "divu_big");
    run_op(32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b1, 32, 32'h00000001, 32'hFFFFFFFD, "div_7bym2");
    run_op(32'd100, 32'd7, 1'b1, 1'b0, 32, 32'd2, 32'd14, "divu_100by7");
  endtask

  task automatic test_div_special();
    run_op(32'h12345678, 32'h0, 1'b1, 1'b1, 32, 32'h12345678, 32'hFFFFFFFF, "div_by0");
    run_op(32'h80000001, 32'h0, 1'b1, 1'b0, 32, 32'h80000001, 32'hFFFFFFFF, "divu_by0");
    run_op(32'hFFFFFFF0, 32'h0, 1'b1, 1'b1, 32, 32'hFFFFFFF0, 32'hFFFFFFFF, "div_neg_by0");
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32, 32'h00000000, 32'h80000000, "div_ovf");
  endtask

  task automatic test_mt();
    logic [31:0] lo0;
    int n;
    lo0 = LO;
    @(negedge Clk); A = 32'hAAAA5555; WriteEnable = 2'b10;
    @(negedge Clk); WriteEnable = 2'b00;
    total++; if (HI !== 32'hAAAA5555) $display("FAIL mthi_HI got %h exp %h", HI, 32'hAAAA5555); else passed++;
    total++; if (LO !== lo0) $display("FAIL mthi_LO got %h exp %h", LO, lo0); else passed++;
    A = 32'h12345678; WriteEnable = 2'b01;
    @(negedge Clk); WriteEnable = 2'b00;
    total++; if (LO !== 32'h12345678) $display("FAIL mtlo_LO got %h exp %h", LO, 32'h12345678); else passed++;
    total++; if (HI !== 32'hAAAA5555) $display("FAIL mtlo_HI got %h exp %h", HI, 32'hAAAA5555); else passed++;
    A = 32'h0F0F0F0F; WriteEnable = 2'b11;
    @(negedge Clk); WriteEnable = 2'b00;
    total++; if (HI !== 32'h0F0F0F0F) $display("FAIL mtboth_HI got %h exp %h", HI, 32'h0F0F0F0F); else passed++;
    total++; if (LO !== 32'h0F0F0F0F) $display("FAIL mtboth_LO got %h exp %h", LO, 32'h0F0F0F0F); else passed++;
    A = 32'd3; B = 32'd4; op = 1'b0; sign = 1'b0; start = 1'b1; WriteEnable = 2'b11;
    @(negedge Clk); start = 1'b0; WriteEnable = 2'b00;
    total++; if (HI !== 32'h0F0F0F0F) $display("FAIL start_wins_HI got %h exp %h", HI, 32'h0F0F0F0F); else passed++;
    total++; if (Busy !== 1'b1) $display("FAIL start_wins_Busy got %b exp 1", Busy); else passed++;
    n = 0;
    while (Busy && n < 200) begin n++; @(negedge Clk); end
    total++; if (HI !== 32'd0) $display("FAIL start_wins_res_HI got %h exp %h", HI, 32'd0); else passed++;
    total++; if (LO !== 32'd12) $display("FAIL start_wins_res_LO got %h exp %h", LO, 32'd12); else passed++;
  endtask

  task automatic test_busy_ignore();
    logic [31:0] hi0, lo0;
    int n;
    hi0 = HI; lo0 = LO;
    @(negedge Clk); A = 32'd100; B = 32'd7; op = 1'b1; sign = 1'b0; start = 1'b1;
    @(negedge Clk);
    A = 32'hDEADBEEF; B = 32'd1; op = 1'b0; start = 1'b1; WriteEnable = 2'b10;
    @(negedge Clk); start = 1'b0; WriteEnable = 2'b00;
    total++; if (HI !== hi0) $display("FAIL busy_mthi_HI got %h exp %h", HI, hi0); else passed++;
    total++; if (LO !== lo0) $display("FAIL busy_mthi_LO got %h exp %h", LO, lo0); else passed++;
    n = 1;
    while (Busy && n < 200) begin n++; @(negedge Clk); end
    total++; if (n !== 32) $display("FAIL busy_ign_latency got %0d exp %0d", n, 32); else passed++;
    total++; if (HI !== 32'd2) $display("FAIL busy_ign_HI got %h exp %h", HI, 32'd2); else passed++;
    total++; if (LO !== 32'd14) $display("FAIL busy_ign_LO got %h exp %h", LO, 32'd14); else passed++;
    @(negedge Clk);
    total++; if (Busy !== 1'b0) $display("FAIL busy_no_queue got %b exp 0", Busy); else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge Clk); A = 32'd6; B = 32'd7; op = 1'b0; sign = 1'b0; start = 1'b1;
    @(negedge Clk); A = 32'd2; B = 32'd3;
    n = 0;
    while (Busy && n < 200) begin n++; @(negedge Clk); end
    total++; if (n !== 5) $display("FAIL b2b_first_latency got %0d exp %0d", n, 5); else passed++;
    total++; if (LO !== 32'd42) $display("FAIL b2b_first_LO got %h exp %h", LO, 32'd42); else passed++;
    @(negedge Clk); start = 1'b0;
    total++; if (Busy !== 1'b1) $display("FAIL b2b_second_accept got %b exp 1", Busy); else passed++;
    n = 0;
    while (Busy && n < 200) begin n++; @(negedge Clk); end
    total++; if (n !== 5) $display("FAIL b2b_second_latency got %0d exp %0d", n, 5); else passed++;
    total++; if (LO !== 32'd6) $display("FAIL b2b_second_LO got %h exp %h", LO, 32'd6); else passed++;
  endtask

  task automatic test_reset_abort();
    @(negedge Clk); A = 32'd100; B = 32'd7; op = 1'b1; sign = 1'b0; start = 1'b1;
    @(negedge Clk); start = 1'b0;
    repeat (9) @(negedge Clk);
    total++; if (Busy !== 1'b1) $display("FAIL abort_pre_Busy got %b exp 1", Busy); else passed++;
    #2 Clr_n = 1'b0;
    #1;
    total++; if (Busy !== 1'b0) $display("FAIL abort_Busy got %b exp 0", Busy); else passed++;
    total++; if (HI !== 32'h0) $display("FAIL abort_HI got %h exp %h", HI, 32'h0); else passed++;
    total++; if (LO !== 32'h0) $display("FAIL abort_LO got %h exp %h", LO, 32'h0); else passed++;
    @(negedge Clk); Clr_n = 1'b1;
    repeat (40) @(negedge Clk);
    total++; if (HI !== 32'h0 || LO !== 32'h0) $display("FAIL abort_no_write got %h_%h exp 0_0", HI, LO); else passed++;
    run_op(32'd3, 32'd5, 1'b0, 1'b0, 5, 32'd0, 32'd15, "post_abort_mul");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_mt();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_core.md
Name: muldiv_core

Overview:
- Multi-cycle integer multiply/divide unit holding the architectural HI/LO pair of a MIPS-style CPU. It sits beside the main ALU in the execute stage.
- It performs MULT/MULTU and DIV/DIVU, and serves MTHI/MTLO writes.
- Busy is asserted while an operation is in flight, so the pipeline can stall on HI/LO reads.
- The block replaces separate multiply and divide cores with one HI/LO register pair.

Parameters:
- MUL_LATENCY, 5, cycles from accepted multiply start to result valid in HI/LO (must be >=1).
- DIV_LATENCY, 32, cycles from accepted divide start to result valid in HI/LO (radix-2, one quotient bit per cycle; fixed at 32).

Ports:
- Clk  input  1  rising-edge clock.
- Clr_n  input  1  asynchronous active-low reset.
- A  input  32  operand A: multiplicand/dividend; also the data for MTHI/MTLO.
- B  input  32  operand B: multiplier/divisor.
- start  input  1  launch operation selected by op/sign; sampled at a rising edge.
- op  input  1  0 = multiply, 1 = divide.
- sign  input  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
- WriteEnable  input  2  bit1 = MTHI (HI<=A), bit0 = MTLO (LO<=A).
- HI  output  32  registered HI: product[63:32] or remainder.
- LO  output  32  registered LO: product[31:0] or quotient.
- Busy  output  1  operation in flight; HI/LO not yet updated.

Behaviour:
- Reset: Clr_n low asynchronously forces HI=0, LO=0, Busy=0, internal counter/state idle, and aborts any in-flight operation; the aborted result is never written.
- States: IDLE, MUL, DIV.
- IDLE -> MUL or DIV happens on a rising edge with start=1 and Busy=0. Operands, op and sign are captured at that edge; A/B may change afterwards.
- Start edge at k:
  - Busy=1 from after edge k through edge k+N-1 (N = MUL_LATENCY or DIV_LATENCY).
  - At edge k+N, HI/LO are loaded with the result and Busy drops to 0. The state returns to IDLE.
  - A back-to-back start is accepted at edge k+N+1 or later.
- start while Busy=1 is ignored; no queuing.
- HI/LO hold their previous values for the whole busy period; no partial results are visible.
- Multiply:
  - signed: {HI,LO} = 64-bit two's-complement product of A and B.
  - unsigned: {HI,LO} = 64-bit zero-extended product.
  - Implementation is free (pipelined or iterative) as long as latency is exactly MUL_LATENCY.
- Divide:
  - LO = quotient, HI = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend; |remainder| < |divisor|.
  - Unsigned: plain 32-bit division.
  - Divide by zero (both modes): LO=0xFFFFFFFF, HI=A. Busy timing is unchanged (DIV_LATENCY).
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- WriteEnable (MTHI/MTLO):
  - Honoured only at an edge with Busy=0 and start=0. HI<=A if bit1; LO<=A if bit0; both may be set.
  - Writes while Busy=1 are ignored; the pipeline stalls on Busy before issuing them.
  - If start=1 and WriteEnable!=0 at the same idle edge, start wins and WriteEnable is ignored.
- The HI/LO register pair is shared between multiply and divide. HI/LO always reflect the most recently completed operation or MT write.

Test Plan:
- Reset, then unsigned multiply A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy high for exactly 5 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
- Signed multiply A=0xFFFFFFFF, B=0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE. Signed -1*-1 -> HI=0, LO=1.
- Signed divide A=0xFFFFFFF9 (-7), B=2 -> after 32 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Unsigned same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- Divide by zero with A=0x12345678 -> LO=0xFFFFFFFF, HI=0x12345678. Signed 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI with A=0xAAAA5555 while idle -> HI=0xAAAA5555, LO unchanged. Repeat during a divide -> ignored. Pulsing start mid-divide -> ignored; the original result is delivered.
- Start a divide, assert Clr_n low at busy cycle 10 -> immediately Busy=0, HI=LO=0. After release, a new multiply completes normally.
